// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master DM arbiter (round-robin + bounded lock) feeding a 3-stage access pipeline.
// Define DM_ARB_ALIGN_CHECK_EN to enable the misaligned-access check (err flag, store suppression).
module dm_arbiter #(
   parameter int BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic        m0_lock,
   input  logic        m1_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m0_sel,
   input  logic [1:0]  m1_sel,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_rvalid,
   output logic        m1_rvalid,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic        m0_err,
   output logic        m1_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_di,
   output logic [1:0]  dm_sel,
   output logic        dm_en,
   input  logic [31:0] dm_do
);

`ifdef DM_ARB_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif
   localparam logic [3:0] BMAX = 4'(BURST_MAX);

   logic [1:0]  req, lck;
   logic        hold, at_max, win_vld, win;
   logic        ptr_q, ptr_d, own_q, own_d;
   logic [3:0]  burst_q, burst_d;

   logic        cmd_vld_q, cmd_id_q, cmd_we_q, cmd_mis_q;
   logic        cmd_id_d, cmd_we_d, cmd_mis_d;
   logic [31:0] cmd_addr_q, cmd_wdata_q, cmd_addr_d, cmd_wdata_d;
   logic [1:0]  cmd_sel_q, cmd_sel_d;

   logic        rsp_vld_q, rsp_id_q, rsp_err_q;
   logic        rsp_vld_d, rsp_id_d, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] sel);
      return ALIGN_EN && (((sel == 2'b00) && (addr[1:0] != 2'b00)) ||
                          ((sel == 2'b01) && addr[0]) || (sel == 2'b11));
   endfunction

   // Stage A: arbitration
   assign req     = {m1_req, m0_req};
   assign lck     = {m1_lock, m0_lock};
   assign win_vld = |req;
   assign at_max  = (burst_q >= BMAX);
   assign hold    = (burst_q != 4'd0) && req[own_q] && lck[own_q];

   always_comb begin
      win = ptr_q;
      if (req == 2'b01)      win = 1'b0;
      else if (req == 2'b10) win = 1'b1;
      else if (hold)         win = at_max ? ~own_q : own_q;
   end

   always_comb begin
      ptr_d   = ptr_q;
      own_d   = own_q;
      burst_d = burst_q;
      if (!win_vld) begin
         burst_d = 4'd0;
      end else if (lck[win]) begin
         own_d = win;
         if ((burst_q != 4'd0) && (own_q == win))
            burst_d = at_max ? burst_q : burst_q + 4'd1;
         else
            burst_d = 4'd1;
         // an exhausted burst handed to the other master also rotates the pointer
         if (at_max && (win != own_q))
            ptr_d = ~win;
      end else begin
         burst_d = 4'd0;
         ptr_d   = ~win;
      end
   end

   always_comb begin
      cmd_id_d    = win;
      cmd_we_d    = win ? m1_we    : m0_we;
      cmd_addr_d  = win ? m1_addr  : m0_addr;
      cmd_wdata_d = win ? m1_wdata : m0_wdata;
      cmd_sel_d   = win ? m1_sel   : m0_sel;
      cmd_mis_d   = misaligned(cmd_addr_d, cmd_sel_d);
   end

   assign m0_gnt = reset & win_vld & ~win;
   assign m1_gnt = reset & win_vld & win;

   // Stage B: DM access from the command register
   assign dm_addr = cmd_addr_q;
   assign dm_di   = cmd_wdata_q;
   assign dm_sel  = cmd_sel_q;
   assign dm_en   = cmd_vld_q & cmd_we_q & ~cmd_mis_q;

   always_comb begin
      rsp_vld_d  = cmd_vld_q;
      rsp_id_d   = cmd_id_q;
      rsp_err_d  = cmd_vld_q & cmd_mis_q;
      rsp_data_d = (cmd_vld_q & ~cmd_we_q & ~cmd_mis_q) ? dm_do : 32'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= 1'b0;
         own_q       <= 1'b0;
         burst_q     <= 4'd0;
         cmd_vld_q   <= 1'b0;
         cmd_id_q    <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_mis_q   <= 1'b0;
         cmd_addr_q  <= 32'd0;
         cmd_wdata_q <= 32'd0;
         cmd_sel_q   <= 2'd0;
         rsp_vld_q   <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'd0;
      end else begin
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         burst_q   <= burst_d;
         cmd_vld_q <= win_vld;
         // command fields hold their last value while idle
         if (win_vld) begin
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_mis_q   <= cmd_mis_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_sel_q   <= cmd_sel_d;
         end
         rsp_vld_q  <= rsp_vld_d;
         rsp_id_q   <= rsp_id_d;
         rsp_err_q  <= rsp_err_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Stage C: response to the owning master
   assign m0_rvalid = rsp_vld_q & ~rsp_id_q;
   assign m1_rvalid = rsp_vld_q & rsp_id_q;
   assign m0_rdata  = m0_rvalid ? rsp_data_q : 32'd0;
   assign m1_rdata  = m1_rvalid ? rsp_data_q : 32'd0;
   assign m0_err    = m0_rvalid & rsp_err_q;
   assign m1_err    = m1_rvalid & rsp_err_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and access sequencer for the data memory (DM). It shares the single DM port between master 0 (CPU MEM stage) and master 1 (loader/debug port), with round-robin priority, an optional bounded lock for back-to-back bursts, and a two-stage registered pipeline. The pipeline drives the DM `Address`/`DI`/`DMsel`/`En` inputs and returns `DO` to the winning master.

## Interface
- `BURST_MAX`, 4: maximum consecutive locked grants to one master (1..15).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held with its fields stable until `mX_gnt`.
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load.
- `m0_lock`, `m1_lock`  in  1  requests priority retention for the next access.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  store data.
- `m0_sel`, `m1_sel`  in  2  width: 00 word, 01 half, 10 byte, 11 reserved.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle; combinational.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle response pulse (loads and stores).
- `m0_rdata`, `m1_rdata`  out  32  load data; 0 for stores.
- `m0_err`, `m1_err`  out  1  alignment error flag, valid with `rvalid`.
- `dm_addr`  out  32  to DM `Address`.
- `dm_di`  out  32  to DM `DI`.
- `dm_sel`  out  2  to DM `DMsel`.
- `dm_en`  out  1  to DM `En` (write enable).
- `dm_do`  in  32  from DM `DO`; combinational read of `dm_addr`.

## Operation
- Stage A (arbitrate), cycle N:
  - Among asserted `req`, pick the winner: the locked owner if a lock is active, else the round-robin pointer holder, else the only requester.
  - Assert that master's `gnt` and register {master id, we, addr, wdata, sel} into the command register with `cmd_valid=1`.
  - If no request is granted, `cmd_valid=0`.
- Round-robin pointer:
  - After any unlocked grant, the pointer moves to the other master.
  - The reset value favours m0.
- Lock:
  - A grant with `lock=1` sets owner = winner and increments `burst_cnt`.
  - While the owner keeps `req` and `lock` high and `burst_cnt < BURST_MAX`, the owner wins even if the other master requests.
  - On `burst_cnt == BURST_MAX` with the other master pending, the other master wins, `burst_cnt` clears and the pointer rotates.
  - Owner dropping `lock` or `req` clears `burst_cnt` immediately.
- Stage B (access), cycle N+1:
  - `dm_addr`/`dm_di`/`dm_sel` come from the command register.
  - `dm_en = cmd_valid & we`; the DM write occurs at the end of N+1.
  - `dm_do` is captured into the response register. For stores, 0 is captured.
- Stage C (respond), cycle N+2:
  - The owning master's `rvalid` pulses with `rdata`/`err`.
  - The other master's outputs stay 0.
- Throughput is one access per cycle. A store in stage B followed by a load in stage A to the same address returns the new data, because the load's stage B comes a cycle later.
- When idle, `dm_*` hold the last command values with `dm_en=0`.

## Timing
- Grant latency: 0 cycles (`gnt` in the same cycle as the winning `req`).
- Load data latency: 2 cycles from `gnt` to `rvalid`.
- Simultaneous requests with no lock: the pointer holder wins; the loser keeps `req` high and is granted next cycle.
- Reset (`reset=0`, asynchronous):
  - Clears `cmd_valid`, response valid, `burst_cnt`, lock owner, and `dm_addr`/`dm_di`/`dm_sel`/`dm_en`, all to 0.
  - Sets the pointer to m0.
  - In-flight accesses are dropped and produce no `rvalid`.
  - A store pending in stage B does not reach DM, since `dm_en` clears asynchronously.
- During reset, `gnt`/`rvalid`/`err` = 0 and `rdata` = 0.

## Configuration
- `DM_ARB_ALIGN_CHECK_EN` defined:
  - In stage A, the command is flagged misaligned when:
    - sel=00 and `addr[1:0]` ≠ 0, or
    - sel=01 and `addr[0]` = 1, or
    - sel=11.
  - A flagged command is granted normally but `dm_en` is forced to 0 in stage B.
  - The response has `err=1` and `rdata=0`.
- Not defined: no check; commands pass to DM unchanged and `err` is tied to 0.

## Test plan
- Single m0 store word `0x87654321` @0x0, then load word @0x0 → `m0_gnt` in the request cycle, `dm_en=1` one cycle later; load `m0_rvalid` 2 cycles after its `gnt` with `rdata=0x87654321`.
- m0 and m1 request loads every cycle for 4 cycles, lock=0 → grants alternate m0,m1,m0,m1; `rvalid` follows each `gnt` 2 cycles later on the matching port.
- BURST_MAX=4: m1 requests continuously with lock=1 while m0 requests continuously with lock=0 → m1 granted 4 consecutive cycles, then m0 granted once, `burst_cnt` returns to 0.
- Back-to-back m1 store byte `0xAA` @0x5 then load byte @0x5 on consecutive cycles → load returns the DM byte-read result of 0xAA with no stale data.
- Assert reset with a store in stage B and a load in stage C → `dm_en` drops immediately and no `rvalid`. After release the DM location is unchanged and the first grant goes to m0 on a tie.
- With `DM_ARB_ALIGN_CHECK_EN`: m0 store word @0x2 → `dm_en` stays 0, `m0_err=1` with `rvalid`. Without the macro: `dm_en=1`, `err=0`.
